moore_probe: RTL and testbench

//  Stimulus/checker end of the Moore-machine lab interface (sw_in/ctrl_in/state_in
//  in, state/out back). Holds a golden next-state/output table, loads the DUT's

---
 rtl/moore_probe.sv | 184 ++++++++++++++++++
 tb/tb_moore_probe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/moore_probe.sv
// Stimulus/checker probe for a Moore-machine lab DUT: golden next-state/output table,
// DUT reset-load, one strobed input per step, and per-step state/output comparison.
module moore_probe #(
  parameter int SW_W   = 2,
  parameter int ST_W   = 3,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [ST_W+SW_W-1:0] cfg_addr,
  input  logic [ST_W-1:0]    cfg_next,
  input  logic               cfg_out,
  input  logic [ST_W-1:0]    init_state,
  input  logic               start,
  input  logic               stim_valid,
  input  logic [SW_W-1:0]    stim_sw,
  input  logic               stim_last,
  output logic               stim_ready,
  output logic               dut_reset,
  output logic [ST_W-1:0]    dut_state_in,
  output logic [SW_W-1:0]    dut_sw,
  output logic               dut_ctrl,
  input  logic [ST_W-1:0]    dut_state,
  input  logic               dut_out,
  output logic               res_valid,
  output logic               res_state_err,
  output logic               res_out_err,
  output logic [ST_W-1:0]    res_exp_state,
  output logic [CNT_W-1:0]   res_step,
  output logic [CNT_W-1:0]   err_count,
  output logic               busy,
  output logic               done
);

  localparam int AW    = ST_W + SW_W;
  localparam int DEPTH = 1 << AW;
  localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_READY  = 3'd3;
  localparam logic [2:0] S_DRIVE  = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_CHECK  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]      state_r;
  logic [2:0]      state_nxt_s;
  logic [ST_W-1:0] next_tab_r [DEPTH];
  logic            out_tab_r  [DEPTH];
  logic [ST_W-1:0] exp_state_r;
  logic            exp_out_r;
  logic            out_known_r;
  logic            last_r;
  logic [CNT_W-1:0] step_r;
  logic [SC_W-1:0] settle_cnt_r;
  logic            accept_s;
  logic [AW-1:0]   tab_idx_s;
  logic            state_err_s;
  logic            out_err_s;

  assign accept_s  = (state_r == S_READY) && stim_valid;
  assign tab_idx_s = {exp_state_r, stim_sw};

  // Mismatch detection against the expected values of the step in flight
  always_comb begin
    state_err_s = (dut_state != exp_state_r);
    out_err_s   = out_known_r && (dut_out != exp_out_r);
  end

  // Sequencer next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_LOAD;
        else       state_nxt_s = S_IDLE;
      end
      S_LOAD:  state_nxt_s = S_WAIT;
      S_WAIT:  state_nxt_s = S_READY;
      S_READY: begin
        if (stim_valid) state_nxt_s = S_DRIVE;
        else            state_nxt_s = S_READY;
      end
      S_DRIVE: state_nxt_s = S_SETTLE;
      S_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) state_nxt_s = S_CHECK;
        else                             state_nxt_s = S_SETTLE;
      end
      S_CHECK: begin
        if (last_r) state_nxt_s = S_DONE;
        else        state_nxt_s = S_READY;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Golden table storage; writable only while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        next_tab_r[i] <= {ST_W{1'b0}};
        out_tab_r[i]  <= 1'b0;
      end
    end else if (cfg_we && (state_r == S_IDLE)) begin
      next_tab_r[cfg_addr] <= cfg_next;
      out_tab_r[cfg_addr]  <= cfg_out;
    end
  end

  // Sequencer state, registered outputs, expectations and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      stim_ready    <= 1'b0;
      dut_reset     <= 1'b0;
      dut_state_in  <= {ST_W{1'b0}};
      dut_sw        <= {SW_W{1'b0}};
      dut_ctrl      <= 1'b0;
      res_valid     <= 1'b0;
      res_state_err <= 1'b0;
      res_out_err   <= 1'b0;
      res_exp_state <= {ST_W{1'b0}};
      res_step      <= {CNT_W{1'b0}};
      err_count     <= {CNT_W{1'b0}};
      busy          <= 1'b0;
      done          <= 1'b0;
      exp_state_r   <= {ST_W{1'b0}};
      exp_out_r     <= 1'b0;
      out_known_r   <= 1'b0;
      last_r        <= 1'b0;
      step_r        <= {CNT_W{1'b0}};
      settle_cnt_r  <= {SC_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      stim_ready <= (state_nxt_s == S_READY);
      dut_reset  <= (state_nxt_s == S_LOAD);
      dut_ctrl   <= (state_nxt_s == S_DRIVE);
      res_valid  <= (state_nxt_s == S_CHECK);
      done       <= (state_nxt_s == S_DONE);
      busy       <= (state_nxt_s != S_IDLE);

      if ((state_r == S_IDLE) && start) begin
        err_count    <= {CNT_W{1'b0}};
        step_r       <= {CNT_W{1'b0}};
        dut_state_in <= init_state;
        exp_state_r  <= init_state;
        out_known_r  <= 1'b0;
      end

      if (accept_s) begin
        dut_sw      <= stim_sw;
        last_r      <= stim_last;
        exp_state_r <= next_tab_r[tab_idx_s];
        exp_out_r   <= out_tab_r[tab_idx_s];
        out_known_r <= 1'b1;
      end

      if (state_r == S_DRIVE) begin
        settle_cnt_r <= {SC_W{1'b0}};
      end else if (state_r == S_SETTLE) begin
        settle_cnt_r <= settle_cnt_r + 1'b1;
      end

      // Results latch on entry to CHECK so they are visible during the CHECK cycle
      if (state_nxt_s == S_CHECK) begin
        res_state_err <= state_err_s;
        res_out_err   <= out_err_s;
        res_exp_state <= exp_state_r;
        res_step      <= step_r;
        step_r        <= step_r + 1'b1;
        if ((state_err_s || out_err_s) && (err_count != {CNT_W{1'b1}})) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_moore_probe.sv
// Directed self-checking bench for moore_probe with a behavioural Moore DUT model
// that can be made to misbehave on demand.
module tb_moore_probe;
  localparam int SW_W = 2, ST_W = 3, SETTLE = 1, CNT_W = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic cfg_we = 1'b0, cfg_out = 1'b0, start = 1'b0;
  logic [ST_W+SW_W-1:0] cfg_addr = '0;
  logic [ST_W-1:0] cfg_next = '0, init_state = '0;
  logic stim_valid = 1'b0, stim_last = 1'b0;
  logic [SW_W-1:0] stim_sw = '0;
  logic stim_ready, dut_reset, dut_ctrl, dut_out;
  logic [ST_W-1:0] dut_state_in, dut_state, res_exp_state;
  logic [SW_W-1:0] dut_sw;
  logic res_valid, res_state_err, res_out_err, busy, done;
  logic [CNT_W-1:0] res_step, err_count;

  int tests = 0, fails = 0;
  int fault = 0;
  logic [ST_W-1:0] dstate = '0;

  always #5 clk = ~clk;

  moore_probe #(.SW_W(SW_W), .ST_W(ST_W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next),
    .cfg_out(cfg_out), .init_state(init_state), .start(start), .stim_valid(stim_valid),
    .stim_sw(stim_sw), .stim_last(stim_last), .stim_ready(stim_ready), .dut_reset(dut_reset),
    .dut_state_in(dut_state_in), .dut_sw(dut_sw), .dut_ctrl(dut_ctrl), .dut_state(dut_state),
    .dut_out(dut_out), .res_valid(res_valid), .res_state_err(res_state_err),
    .res_out_err(res_out_err), .res_exp_state(res_exp_state), .res_step(res_step),
    .err_count(err_count), .busy(busy), .done(done)
  );

  // Lab FSM: s0 sw0->s0, s0 other->s1; s1 sw0/2->s1, s1 sw1/3->s0; output 1 in s0
  function automatic logic [ST_W-1:0] mnext(input logic [ST_W-1:0] s, input logic [SW_W-1:0] sw);
    if (fault == 1 && s == 3'd0 && sw == 2'd1) return 3'd3;
    case (s)
      3'd0:    return (sw == 2'd0) ? 3'd0 : 3'd1;
      3'd1:    return (sw[0] == 1'b0) ? 3'd1 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (dut_reset) dstate <= dut_state_in;
    else if (dut_ctrl) dstate <= mnext(dstate, dut_sw);
  end
  assign dut_state = (fault == 2) ? (dstate ^ 3'd4) : dstate;
  assign dut_out   = (dstate == 3'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_table();
    for (int s = 0; s < 2; s++) begin
      for (int sw = 0; sw < 4; sw++) begin
        cfg_we   = 1'b1;
        cfg_addr = 5'(s * 4 + sw);
        cfg_next = (s == 0) ? ((sw == 0) ? 3'd0 : 3'd1) : ((sw % 2 == 0) ? 3'd1 : 3'd0);
        cfg_out  = (cfg_next == 3'd0);
        tick();
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input logic [ST_W-1:0] init);
    init_state = init;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!stim_ready && n < 50) begin tick(); n++; end
    check("ready_timeout", stim_ready, 1);
  endtask

  task automatic step(input logic [1:0] sw, input logic last, input logic [2:0] exp_st,
                      input logic st_err, input logic out_err, input int exp_step, input int exp_errs);
    int n;
    wait_ready();
    stim_valid = 1'b1; stim_sw = sw; stim_last = last;
    tick();
    stim_valid = 1'b0; stim_last = 1'b0;
    n = 1;
    while (!res_valid && n < 20) begin tick(); n++; end
    check("latency", n, SETTLE + 2);
    check("res_exp_state", res_exp_state, exp_st);
    check("res_state_err", res_state_err, st_err);
    check("res_out_err", res_out_err, out_err);
    check("res_step", res_step, exp_step);
    check("err_count", err_count, exp_errs);
  endtask

  task automatic finish_run(input int exp_errs);
    tick();
    check("done_pulse", done, 1);
    check("final_err_count", err_count, exp_errs);
    tick();
    check("done_cleared", done, 0);
    check("busy_cleared", busy, 0);
  endtask

  initial begin
    int cnt;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("reset_outs", {busy, done, stim_ready, dut_reset, dut_ctrl, res_valid, err_count,
                         dut_sw, dut_state_in, res_step}, 0);
    load_table();

    // Matching DUT walks 0,1,1,0
    start_run(3'd0);
    step(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0, 0);
    step(2'd1, 1'b0, 3'd1, 1'b0, 1'b0, 1, 0);
    step(2'd2, 1'b0, 3'd1, 1'b0, 1'b0, 2, 0);
    step(2'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3, 0);
    finish_run(0);

    // DUT sends s0/sw1 to s3
    fault = 1;
    start_run(3'd0);
    step(2'd1, 1'b1, 3'd1, 1'b1, 1'b0, 0, 1);
    finish_run(1);
    fault = 0;

    // Reset-load of state 1: one-cycle dut_reset pulse
    start_run(3'd1);
    check("load_state_in", dut_state_in, 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (dut_reset) cnt++;
      tick();
    end
    check("dut_reset_cycles", cnt, 1);
    check("state_in_held", dut_state_in, 1);
    step(2'd0, 1'b1, 3'd1, 1'b0, 1'b0, 0, 0);
    finish_run(0);

    // Idle in READY: no strobe, no result
    start_run(3'd0);
    wait_ready();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (dut_ctrl || res_valid) cnt++;
      tick();
    end
    check("idle_ready_activity", cnt, 0);
    check("still_ready", stim_ready, 1);
    step(2'd1, 1'b1, 3'd1, 1'b0, 1'b0, 0, 0);
    finish_run(0);

    // 300 mismatching steps; cfg write and start while busy must be ignored
    fault = 2;
    start_run(3'd0);
    wait_ready();
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_next = 3'd5; cfg_out = 1'b0; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(2'd0, (i == 299), 3'd0, 1'b1, 1'b0, i % 256, (i + 1 > 255) ? 255 : i + 1);
    end
    finish_run(255);
    fault = 0;

    // Reset during SETTLE aborts the run
    start_run(3'd0);
    wait_ready();
    stim_valid = 1'b1; stim_sw = 2'd1;
    tick();
    stim_valid = 1'b0;
    check("drive_strobe", dut_ctrl, 1);
    tick();
    check("settle_no_strobe", dut_ctrl, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_outs", {busy, done, stim_ready, dut_reset, dut_ctrl, res_valid, err_count,
                         dut_sw, dut_state_in, res_step, res_exp_state}, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid || done || busy) cnt++;
      tick();
    end
    check("abort_quiet", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
